if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Generates the PC and issues single-outstanding requests to the instruction SRAM port.
- Buffers returned words and presents {pc_o, inst_o, valid_o} as the IF/ID pipeline register that feeds decode's pc_i/inst_i.
- Handles decode back-pressure (stall_i) and branch redirects from EX.

Parameters:
- RESET_PC, 32'h1C00_0000, first fetch address after reset (LoongArch reset vector).
- NOP_INST, 32'h0340_0000, word driven on inst_o when valid_o=0 (andi r0,r0,0).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset: synchronous, active-high
- inst_req_o  out  1  fetch request valid
- inst_addr_o  out  32  fetch address; word-aligned in normal operation
- inst_gnt_i  in  1  SRAM accepts the request this cycle
- inst_rvalid_i  in  1  read data valid; arrives at least 1 cycle after grant, in order
- inst_rdata_i  in  32  read data
- stall_i  in  1  decode cannot accept this cycle
- branch_flag_i  in  1  redirect request from EX
- branch_target_i  in  32  redirect address
- pc_o  out  32  PC of the instruction presented to decode
- inst_o  out  32  instruction presented to decode
- valid_o  out  1  pc_o/inst_o hold a real instruction

Behaviour:
- Reset (rst=1 at posedge) values:
  - pc register = RESET_PC
  - inst_req_o = 0
  - valid_o = 0, pc_o = 0, inst_o = NOP_INST
  - skid buffer empty; drop flag = 0
  - FSM = IDLE
- Reset applied mid-operation discards any outstanding response. An inst_rvalid_i arriving after reset is ignored while the drop flag is set. Reset sets drop=1 only if a granted request was pending.
- FSM states:
  - IDLE: next cycle goes to REQ.
  - REQ: inst_req_o=1, inst_addr_o=pc. On inst_gnt_i, go to WAIT and pc <= pc+4.
  - WAIT: waiting for the response. On inst_rvalid_i, go to REQ if a slot will be free, else HOLD.
  - HOLD: output register and skid buffer both full. Return to REQ when the skid buffer drains.
- Request rules:
  - While inst_req_o=1 and not granted, inst_addr_o and inst_req_o stay stable, including across a redirect.
  - At most one request is outstanding.
  - A new request is issued only when the skid buffer is empty.
- Response routing:
  - If valid_o=0, or stall_i=0, the response loads {pc_o, inst_o} and valid_o=1 next cycle.
  - Otherwise it goes to the 1-entry skid buffer.
- Skid buffer drains into the output register the first cycle stall_i=0. Skid contents always precede a newer response.
- Output: decode consumes when valid_o=1 and stall_i=0. With no new data, valid_o falls to 0 and inst_o=NOP_INST.
- Latency: grant at cycle N and rvalid at N+1 give valid_o=1 at N+2. Throughput is 1 instruction per 2 cycles with single-cycle SRAM.
- Redirect (branch_flag_i=1):
  - Has priority over stall_i and over any response in the same cycle.
  - Next cycle: valid_o=0, skid cleared, pc <= branch_target_i.
  - Outstanding granted request: drop=1, and its response is discarded (drop cleared on that rvalid).
  - Ungranted request: completes at its old address, and its response is dropped.
  - Fetch from the target starts after that.
- A redirect together with an rvalid in the same cycle discards that rvalid.
- PC wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). No special handling.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- When defined:
  - Adds output adef_o (1 bit).
  - A redirect target with [1:0]!=0 is not fetched. The stage presents pc_o=target, inst_o=NOP_INST, valid_o=1, adef_o=1, then idles until the next redirect.
  - adef_o resets to 0 and clears on redirect.
- When undefined: no port, and targets are used as-is with bits [1:0] forced to 0.

Decomposition:
- Shared Defines include gains:
  - RESET_PC value
  - NOP_INST encoding
  - FSM state encodings (IF_IDLE/IF_REQ/IF_WAIT/IF_HOLD, 2 bits)
  - InstAddrBus/InstBus widths (reused)
- One natural sub-module: if_skid_buf (1-entry {pc, inst} buffer with push/pop/flush).

Test Plan:
- Reset release, SRAM grants immediately, rvalid 1 cycle later, no stall -> inst_addr_o sequence 1C000000, 1C000004, 1C000008. pc_o/inst_o match with valid_o=1 two cycles after each grant.
- Hold stall_i=1 for 5 cycles after the first instruction -> output frozen at pc 1C000000. Second word held in skid. No third request issued. On release, pc 1C000004 follows on the next cycle.
- Redirect to 1C000100 while the request to 1C000008 is granted and awaiting rvalid -> that response is discarded. valid_o=0 for the flush cycle. Next fetched pc_o = 1C000100.
- inst_gnt_i held low 3 cycles while a redirect arrives -> inst_addr_o stable at the old address until grant. Its data is dropped. The next request is to the target.
- Assert rst in WAIT with rvalid arriving the following cycle -> all outputs at reset values. The stale response is ignored. First fetch is RESET_PC.
- IF_ALIGN_CHECK_EN: redirect to 1C000102 -> valid_o=1, adef_o=1, pc_o=1C000102, inst_o=03400000, and no inst_req_o until the next redirect.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset vector, NOP encoding,
// bus widths and FSM state encodings.
package if_stage_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstAddrBus-1:0] DEF_RESET_PC = 32'h1C00_0000;
  localparam logic [InstBus-1:0]     DEF_NOP_INST = 32'h0340_0000;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_HOLD = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, inst} skid buffer. Flush wins over push; push wins over pop.
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [InstAddrBus-1:0] pc_i,
  input  logic [InstBus-1:0]     inst_i,
  output logic                   full_o,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstBus-1:0]     inst_o
);

  logic                   full_q, full_d;
  logic [InstAddrBus-1:0] pc_q;
  logic [InstBus-1:0]     inst_q;

  always_comb begin
    full_d = full_q;
    if (flush_i)     full_d = 1'b0;
    else if (push_i) full_d = 1'b1;
    else if (pop_i)  full_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) full_q <= 1'b0;
    else     full_q <= full_d;
  end

  // Payload needs no reset: it is only observed while full_q is set.
  always_ff @(posedge clk) begin
    if (push_i) begin
      pc_q   <= pc_i;
      inst_q <= inst_i;
    end
  end

  assign full_o = full_q;
  assign pc_o   = pc_q;
  assign inst_o = inst_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, single-outstanding SRAM requests and the
// IF/ID register with a skid buffer. Optional macro IF_ALIGN_CHECK_EN adds adef_o.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [InstBus-1:0]     NOP_INST = DEF_NOP_INST
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   inst_req_o,
  output logic [InstAddrBus-1:0] inst_addr_o,
  input  logic                   inst_gnt_i,
  input  logic                   inst_rvalid_i,
  input  logic [InstBus-1:0]     inst_rdata_i,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_i,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstBus-1:0]     inst_o,
`ifdef IF_ALIGN_CHECK_EN
  output logic                   adef_o,
`endif
  output logic                   valid_o
);

  if_state_e              state_q, state_d;
  logic [InstAddrBus-1:0] pc_q, pc_d, tgt_q, tgt_d, rspPc_q, rspPc_d, outPc_q, outPc_d;
  logic [InstBus-1:0]     outInst_q, outInst_d;
  logic                   req_q, req_d, drop_q, drop_d, redirPend_q, redirPend_d;
  logic                   outValid_q, outValid_d, adef_q, adef_d;
  logic [InstAddrBus-1:0] tgtAddr;
  logic                   misaligned, rspFire, outFree, rstDrop;
  logic                   skidFull, skidPush, skidPop, skidFlush;
  logic [InstAddrBus-1:0] skidPc;
  logic [InstBus-1:0]     skidInst;

  assign tgtAddr = branch_target_i & 32'hFFFF_FFFC;
`ifdef IF_ALIGN_CHECK_EN
  assign misaligned = |branch_target_i[1:0];
  assign adef_o     = adef_q;
`else
  assign misaligned = 1'b0;
`endif

  assign outFree = !outValid_q || !stall_i;
  assign rspFire = inst_rvalid_i && !drop_q && (state_q == IF_WAIT);
  // A response still owed to us at reset (pending or granted this cycle) must be dropped.
  assign rstDrop = ((state_q == IF_WAIT || drop_q) && !inst_rvalid_i) || (req_q && inst_gnt_i);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    rspPc_d     = rspPc_q;
    drop_d      = drop_q;
    redirPend_d = redirPend_q;
    outValid_d  = outValid_q;
    outPc_d     = outPc_q;
    outInst_d   = outInst_q;
    adef_d      = adef_q;
    skidPush    = 1'b0;
    skidPop     = 1'b0;
    skidFlush   = 1'b0;

    if (inst_rvalid_i && drop_q) drop_d = 1'b0;
    if (req_q && inst_gnt_i) rspPc_d = pc_q;

    if (branch_flag_i) begin
      skidFlush  = 1'b1;
      outValid_d = misaligned;
      outPc_d    = misaligned ? branch_target_i : outPc_q;
      outInst_d  = NOP_INST;
      adef_d     = misaligned;
      case (state_q)
        IF_REQ: begin
          if (req_q && inst_gnt_i) begin
            state_d     = IF_WAIT;
            drop_d      = 1'b1;
            pc_d        = tgtAddr;
            redirPend_d = 1'b0;
          end else if (req_q) begin
            redirPend_d = 1'b1;
            tgt_d       = tgtAddr;
          end else begin
            pc_d = tgtAddr;
          end
        end
        IF_WAIT: begin
          pc_d    = tgtAddr;
          drop_d  = !inst_rvalid_i;
          state_d = inst_rvalid_i ? IF_REQ : IF_WAIT;
        end
        default: begin
          pc_d    = tgtAddr;
          state_d = IF_REQ;
        end
      endcase
    end else begin
      // Skid contents always go to decode before any newer response.
      if (skidFull && outFree) begin
        skidPop    = 1'b1;
        outValid_d = 1'b1;
        outPc_d    = skidPc;
        outInst_d  = skidInst;
      end else if (rspFire && outFree) begin
        outValid_d = 1'b1;
        outPc_d    = rspPc_q;
        outInst_d  = inst_rdata_i;
      end else if (rspFire) begin
        skidPush = 1'b1;
      end else if (outValid_q && !stall_i) begin
        outValid_d = 1'b0;
        outInst_d  = NOP_INST;
      end

      case (state_q)
        IF_IDLE: state_d = IF_REQ;
        IF_REQ: begin
          if (req_q && inst_gnt_i) begin
            state_d     = IF_WAIT;
            pc_d        = redirPend_q ? tgt_q : pc_q + 32'd4;
            drop_d      = redirPend_q;
            redirPend_d = 1'b0;
          end
        end
        IF_WAIT: begin
          if (inst_rvalid_i) state_d = skidPush ? IF_HOLD : IF_REQ;
        end
        IF_HOLD: begin
          if (skidPop) state_d = IF_REQ;
        end
        default: state_d = IF_IDLE;
      endcase
    end

    req_d = (state_d == IF_REQ) && !drop_d && (!adef_d || redirPend_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IF_IDLE;
      pc_q        <= RESET_PC;
      tgt_q       <= RESET_PC;
      rspPc_q     <= RESET_PC;
      req_q       <= 1'b0;
      drop_q      <= rstDrop;
      redirPend_q <= 1'b0;
      outValid_q  <= 1'b0;
      outPc_q     <= '0;
      outInst_q   <= NOP_INST;
      adef_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      rspPc_q     <= rspPc_d;
      req_q       <= req_d;
      drop_q      <= drop_d;
      redirPend_q <= redirPend_d;
      outValid_q  <= outValid_d;
      outPc_q     <= outPc_d;
      outInst_q   <= outInst_d;
      adef_q      <= adef_d;
    end
  end

  if_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush_i (skidFlush),
    .push_i  (skidPush),
    .pop_i   (skidPop),
    .pc_i    (rspPc_q),
    .inst_i  (inst_rdata_i),
    .full_o  (skidFull),
    .pc_o    (skidPc),
    .inst_o  (skidInst)
  );

  assign inst_req_o  = req_q;
  assign inst_addr_o = pc_q;
  assign pc_o        = outPc_q;
  assign inst_o      = outInst_q;
  assign valid_o     = outValid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; the SRAM model returns ~address as data after a
// programmable number of cycles. Inputs change and outputs are sampled on negedge.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_gnt_i = 1'b0;
  logic        inst_rvalid_i = 1'b0;
  logic [31:0] inst_rdata_i = '0;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
`ifdef IF_ALIGN_CHECK_EN
  logic        adef_o;
`endif

  int          total = 0;
  int          bad = 0;
  int          lat = 1;
  int          cnt = 0;
  logic        gntEn = 1'b1;
  logic [31:0] rspData = '0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .inst_req_o      (inst_req_o),
    .inst_addr_o     (inst_addr_o),
    .inst_gnt_i      (inst_gnt_i),
    .inst_rvalid_i   (inst_rvalid_i),
    .inst_rdata_i    (inst_rdata_i),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
`ifdef IF_ALIGN_CHECK_EN
    .adef_o          (adef_o),
`endif
    .valid_o         (valid_o)
  );

  // One clock: drive SRAM handshake for the coming edge, then settle to negedge.
  task automatic stepCycle();
    logic        granted;
    logic [31:0] gAddr;
    inst_rvalid_i = (cnt == 1);
    inst_rdata_i  = rspData;
    inst_gnt_i    = gntEn && inst_req_o;
    granted       = inst_gnt_i;
    gAddr         = inst_addr_o;
    @(posedge clk);
    if (granted) begin
      cnt     = lat;
      rspData = ~gAddr;
    end else if (cnt > 0) begin
      cnt--;
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; gntEn = 1'b1; lat = 1; cnt = 0;
    stepCycle();
    stepCycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    total++;
    if (inst_req_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %b want 0", inst_req_o); end
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", valid_o); end
    total++;
    if (pc_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc: got %h want 00000000", pc_o); end
    total++;
    if (inst_o !== 32'h0340_0000) begin bad++; $display("[TB] FAIL reset_inst: got %h want 03400000", inst_o); end
`ifdef IF_ALIGN_CHECK_EN
    total++;
    if (adef_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_adef: got %b want 0", adef_o); end
`endif
  endtask

  task automatic test_fetch();
    logic [31:0] expAddr [3];
    logic [31:0] expInst [3];
    expAddr = '{32'h1C00_0000, 32'h1C00_0004, 32'h1C00_0008};
    expInst = '{32'hE3FF_FFFF, 32'hE3FF_FFFB, 32'hE3FF_FFF7};
    doReset();
    stepCycle();
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({inst_req_o, inst_addr_o} !== {1'b1, expAddr[k]}) begin
        bad++; $display("[TB] FAIL fetch_req%0d: got req=%b addr=%h want req=1 addr=%h", k, inst_req_o, inst_addr_o, expAddr[k]);
      end
      stepCycle();
      stepCycle();
      total++;
      if ({valid_o, pc_o, inst_o} !== {1'b1, expAddr[k], expInst[k]}) begin
        bad++; $display("[TB] FAIL fetch_out%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", k, valid_o, pc_o, inst_o, expAddr[k], expInst[k]);
      end
    end
  endtask

  task automatic test_stall();
    doReset();
    stepCycle();
    stepCycle();
    stepCycle();
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      total++;
      if ({valid_o, pc_o, inst_o, inst_req_o} !== {1'b1, 32'h1C00_0000, 32'hE3FF_FFFF, 1'b0}) begin
        bad++; $display("[TB] FAIL stall_hold%0d: got v=%b pc=%h inst=%h req=%b want v=1 pc=1c000000 inst=e3ffffff req=0", i, valid_o, pc_o, inst_o, inst_req_o);
      end
    end
    stall_i = 1'b0;
    stepCycle();
    total++;
    if ({valid_o, pc_o, inst_o} !== {1'b1, 32'h1C00_0004, 32'hE3FF_FFFB}) begin
      bad++; $display("[TB] FAIL stall_drain: got v=%b pc=%h inst=%h want v=1 pc=1c000004 inst=e3fffffb", valid_o, pc_o, inst_o);
    end
    total++;
    if ({inst_req_o, inst_addr_o} !== {1'b1, 32'h1C00_0008}) begin
      bad++; $display("[TB] FAIL stall_nextreq: got req=%b addr=%h want req=1 addr=1c000008", inst_req_o, inst_addr_o);
    end
  endtask

  task automatic test_redirect();
    doReset();
    for (int i = 0; i < 5; i++) stepCycle();
    stall_i = 1'b1;
    lat = 3;
    stepCycle();
    total++;
    if ({valid_o, pc_o} !== {1'b1, 32'h1C00_0004}) begin
      bad++; $display("[TB] FAIL redir_pre: got v=%b pc=%h want v=1 pc=1c000004", valid_o, pc_o);
    end
    branch_flag_i = 1'b1; branch_target_i = 32'h1C00_0100;
    stepCycle();
    branch_flag_i = 1'b0; stall_i = 1'b0;
    total++;
    if ({valid_o, inst_o, inst_req_o} !== {1'b0, 32'h0340_0000, 1'b0}) begin
      bad++; $display("[TB] FAIL redir_flush: got v=%b inst=%h req=%b want v=0 inst=03400000 req=0", valid_o, inst_o, inst_req_o);
    end
    stepCycle();
    stepCycle();
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL redir_drop: got v=%b want 0", valid_o); end
    total++;
    if ({inst_req_o, inst_addr_o} !== {1'b1, 32'h1C00_0100}) begin
      bad++; $display("[TB] FAIL redir_req: got req=%b addr=%h want req=1 addr=1c000100", inst_req_o, inst_addr_o);
    end
    lat = 1;
    stepCycle();
    stepCycle();
    total++;
    if ({valid_o, pc_o, inst_o} !== {1'b1, 32'h1C00_0100, 32'hE3FF_FEFF}) begin
      bad++; $display("[TB] FAIL redir_out: got v=%b pc=%h inst=%h want v=1 pc=1c000100 inst=e3fffeff", valid_o, pc_o, inst_o);
    end
  endtask

  task automatic test_gnt_hold();
    doReset();
    stepCycle();
    gntEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      branch_flag_i = (i == 1); branch_target_i = 32'h1C00_0200;
      stepCycle();
      total++;
      if ({inst_req_o, inst_addr_o} !== {1'b1, 32'h1C00_0000}) begin
        bad++; $display("[TB] FAIL gnthold_stable%0d: got req=%b addr=%h want req=1 addr=1c000000", i, inst_req_o, inst_addr_o);
      end
    end
    branch_flag_i = 1'b0;
    gntEn = 1'b1;
    stepCycle();
    total++;
    if (inst_req_o !== 1'b0) begin bad++; $display("[TB] FAIL gnthold_wait: got req=%b want 0", inst_req_o); end
    stepCycle();
    total++;
    if ({valid_o, inst_req_o, inst_addr_o} !== {1'b0, 1'b1, 32'h1C00_0200}) begin
      bad++; $display("[TB] FAIL gnthold_target: got v=%b req=%b addr=%h want v=0 req=1 addr=1c000200", valid_o, inst_req_o, inst_addr_o);
    end
    stepCycle();
    stepCycle();
    total++;
    if ({valid_o, pc_o, inst_o} !== {1'b1, 32'h1C00_0200, 32'hE3FF_FDFF}) begin
      bad++; $display("[TB] FAIL gnthold_out: got v=%b pc=%h inst=%h want v=1 pc=1c000200 inst=e3fffdff", valid_o, pc_o, inst_o);
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    stepCycle();
    stepCycle();
    stepCycle();
    stall_i = 1'b1;
    lat = 2;
    stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0; stall_i = 1'b0;
    total++;
    if ({inst_req_o, valid_o, pc_o, inst_o} !== {1'b0, 1'b0, 32'h0, 32'h0340_0000}) begin
      bad++; $display("[TB] FAIL rstmid_vals: got req=%b v=%b pc=%h inst=%h want req=0 v=0 pc=00000000 inst=03400000", inst_req_o, valid_o, pc_o, inst_o);
    end
    stepCycle();
    total++;
    if ({valid_o, inst_req_o, inst_addr_o} !== {1'b0, 1'b1, 32'h1C00_0000}) begin
      bad++; $display("[TB] FAIL rstmid_stale: got v=%b req=%b addr=%h want v=0 req=1 addr=1c000000", valid_o, inst_req_o, inst_addr_o);
    end
    lat = 1;
    stepCycle();
    stepCycle();
    total++;
    if ({valid_o, pc_o, inst_o} !== {1'b1, 32'h1C00_0000, 32'hE3FF_FFFF}) begin
      bad++; $display("[TB] FAIL rstmid_out: got v=%b pc=%h inst=%h want v=1 pc=1c000000 inst=e3ffffff", valid_o, pc_o, inst_o);
    end
  endtask

`ifdef IF_ALIGN_CHECK_EN
  task automatic test_align();
    doReset();
    stepCycle();
    branch_flag_i = 1'b1; branch_target_i = 32'h1C00_0102;
    stepCycle();
    branch_flag_i = 1'b0;
    total++;
    if ({valid_o, adef_o, pc_o, inst_o} !== {1'b1, 1'b1, 32'h1C00_0102, 32'h0340_0000}) begin
      bad++; $display("[TB] FAIL align_adef: got v=%b adef=%b pc=%h inst=%h want v=1 adef=1 pc=1c000102 inst=03400000", valid_o, adef_o, pc_o, inst_o);
    end
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      total++;
      if (inst_req_o !== 1'b0) begin bad++; $display("[TB] FAIL align_idle%0d: got req=%b want 0", i, inst_req_o); end
    end
    branch_flag_i = 1'b1; branch_target_i = 32'h1C00_0300;
    stepCycle();
    branch_flag_i = 1'b0;
    total++;
    if ({adef_o, inst_req_o, inst_addr_o} !== {1'b0, 1'b1, 32'h1C00_0300}) begin
      bad++; $display("[TB] FAIL align_resume: got adef=%b req=%b addr=%h want adef=0 req=1 addr=1c000300", adef_o, inst_req_o, inst_addr_o);
    end
  endtask
`else
  task automatic test_align();
    doReset();
    stepCycle();
    branch_flag_i = 1'b1; branch_target_i = 32'h1C00_0106;
    stepCycle();
    branch_flag_i = 1'b0;
    stepCycle();
    total++;
    if ({inst_req_o, inst_addr_o} !== {1'b1, 32'h1C00_0104}) begin
      bad++; $display("[TB] FAIL align_mask: got req=%b addr=%h want req=1 addr=1c000104", inst_req_o, inst_addr_o);
    end
    stepCycle();
    stepCycle();
    total++;
    if ({valid_o, pc_o, inst_o} !== {1'b1, 32'h1C00_0104, 32'hE3FF_FEFB}) begin
      bad++; $display("[TB] FAIL align_out: got v=%b pc=%h inst=%h want v=1 pc=1c000104 inst=e3fffefb", valid_o, pc_o, inst_o);
    end
  endtask
`endif

  initial begin
    $display("[TB] if_stage directed tests");
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_gnt_hold();
    test_reset_mid();
    test_align();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
